// File: rtl/data_ram_wr_arbiter.sv
// data_ram_wr_arbiter: owns the write port (port B) of the data-table RAM.
// It shares that port round-robin between REQ_CNT write requesters and holds
// the RAM clear sequencer, which writes zero to every address on request.
// Optional build macro DATA_RAM_WR_ARB_STALL_CNT_EN adds a 16-bit saturating
// counter, stall_cnt_o, of cycles in which a valid request was not granted.
module data_ram_wr_arbiter #(
    parameter int REQ_CNT = 3,
    parameter int A_WIDTH = 10,
    parameter int D_WIDTH = 64
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [REQ_CNT*A_WIDTH-1:0] req_addr_i,
    input  logic [REQ_CNT*D_WIDTH-1:0] req_data_i,
    input  logic [REQ_CNT-1:0]         req_valid_i,
    output logic [REQ_CNT-1:0]         req_ready_o,
    input  logic                       clear_run_i,
    output logic                       clear_busy_o,
    output logic                       clear_done_o,
    output logic [A_WIDTH-1:0]         ram_wr_addr_o,
    output logic [D_WIDTH-1:0]         ram_wr_data_o,
`ifdef DATA_RAM_WR_ARB_STALL_CNT_EN
    output logic [15:0]                stall_cnt_o,
`endif
    output logic                       ram_wr_en_o
);

    localparam int PTR_W = (REQ_CNT > 1) ? $clog2(REQ_CNT) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state;
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   next_ptr;
    logic [A_WIDTH-1:0] clear_addr;
    logic               grant_valid;
    logic [A_WIDTH-1:0] sel_addr;
    logic [D_WIDTH-1:0] sel_data;
    int                 idx;

    // Round-robin search from rr_ptr upward with wrap; only IDLE grants, and a
    // clear request in the same cycle suppresses every grant.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        req_ready_o = '0;
        grant_valid = 1'b0;
        sel_addr    = '0;
        sel_data    = '0;
        next_ptr    = rr_ptr;
        idx         = 0;
        if (state == IDLE && !clear_run_i) begin
            for (int k = 0; k < REQ_CNT; k++) begin
                idx = int'(rr_ptr) + k;
                if (idx >= REQ_CNT) idx = idx - REQ_CNT;
                if (!grant_valid && req_valid_i[idx]) begin
                    grant_valid      = 1'b1;
                    req_ready_o[idx] = 1'b1;
                    sel_addr         = req_addr_i[idx*A_WIDTH +: A_WIDTH];
                    sel_data         = req_data_i[idx*D_WIDTH +: D_WIDTH];
                    next_ptr         = (idx == REQ_CNT - 1) ? '0 : PTR_W'(idx + 1);
                end
            end
        end
    end

    // FSM plus registered RAM write port and clear status outputs.
    always_ff @(posedge clk_i) begin
        // NOTE: state is written with <= so every flop samples pre-edge values.
        if (!rst_i) begin
            // NOTE: the synchronous reset clears every flop here, aborting any clear in flight.
            state         <= IDLE;
            rr_ptr        <= '0;
            clear_addr    <= '0;
            ram_wr_en_o   <= 1'b0;
            ram_wr_addr_o <= '0;
            ram_wr_data_o <= '0;
            clear_busy_o  <= 1'b0;
            clear_done_o  <= 1'b0;
        end else begin
            ram_wr_en_o  <= 1'b0;
            clear_done_o <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (clear_run_i) begin
                        state        <= CLEAR;
                        clear_addr   <= '0;
                        clear_busy_o <= 1'b1;
                    end else begin
                        state <= IDLE;
                        if (grant_valid) begin
                            ram_wr_addr_o <= sel_addr;
                            ram_wr_data_o <= sel_data;
                            ram_wr_en_o   <= 1'b1;
                            rr_ptr        <= next_ptr;
                        end
                    end
                end
                CLEAR: begin
                    ram_wr_addr_o <= clear_addr;
                    ram_wr_data_o <= '0;
                    ram_wr_en_o   <= 1'b1;
                    clear_addr    <= clear_addr + 1'b1;
                    if (clear_addr == '1) begin
                        state        <= DONE;
                        clear_busy_o <= 1'b0;
                        clear_done_o <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DATA_RAM_WR_ARB_STALL_CNT_EN
    // Saturating count of cycles with a valid request left ungranted.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            stall_cnt_o <= '0;
        end else if (clear_run_i) begin
            stall_cnt_o <= '0;
        end else if (|(req_valid_i & ~req_ready_o) && stall_cnt_o != 16'hFFFF) begin
            stall_cnt_o <= stall_cnt_o + 16'd1;
        end
    end
`endif

endmodule
